// File: rtl/muldiv_execute_unit.sv
// muldiv_execute_unit: iterative RV32M multiply/divide for the Execute stage.
// Radix-2 shift-add multiply and restoring divide on magnitudes; sign fixed up on the last step.
module muldiv_execute_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start_e,
    input  logic [2:0]      i_muldiv_op_e,
    input  logic [XLEN-1:0] i_src_a_e,
    input  logic [XLEN-1:0] i_src_b_e,
    input  logic            i_kill_e,
    output logic            o_busy_e,
    output logic            o_done_e,
    output logic [XLEN-1:0] o_muldiv_result_e
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t              r_state, w_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_op;
    logic [XLEN-1:0]     r_m, r_rem, r_result;
    logic [2*XLEN-1:0]   r_acc;
    logic                r_neg, r_neg_a, r_bz;
    logic                w_accept, w_sa, w_sb, w_qbit;
    logic [XLEN-1:0]     w_mag_a, w_mag_b, w_sub, w_rem_n, w_quo, w_remv, w_res;
    logic [XLEN:0]       w_sum, w_sh;
    logic [2*XLEN-1:0]   w_acc_n, w_prod;

    assign w_accept = (r_state == IDLE) & i_start_e & ~i_kill_e;
    assign o_busy_e = i_rst_n & (w_accept | (r_state == CALC));
    assign o_done_e = (r_state == DONE);
    assign o_muldiv_result_e = r_result;

    // Divide ops are signed only for DIV/REM; multiply sign handling follows MUL/MULH/MULHSU/MULHU
    assign w_sa    = (i_muldiv_op_e[2] ? ~i_muldiv_op_e[0] : (i_muldiv_op_e[1:0] != 2'b11)) & i_src_a_e[XLEN-1];
    assign w_sb    = (i_muldiv_op_e[2] ? ~i_muldiv_op_e[0] : ~i_muldiv_op_e[1]) & i_src_b_e[XLEN-1];
    assign w_mag_a = w_sa ? -i_src_a_e : i_src_a_e;
    assign w_mag_b = w_sb ? -i_src_b_e : i_src_b_e;

    // r_acc low half holds multiplier (mul) or dividend/quotient (div); r_m is multiplicand or divisor
    assign w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_m} : '0);
    assign w_sh    = {r_rem, r_acc[XLEN-1]};
    assign w_qbit  = w_sh >= {1'b0, r_m};
    assign w_sub   = XLEN'(w_sh - {1'b0, r_m});
    assign w_rem_n = w_qbit ? w_sub : w_sh[XLEN-1:0];
    assign w_acc_n = r_op[2] ? {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-2:0], w_qbit} : {w_sum, r_acc[XLEN-1:1]};
    assign w_prod  = r_neg ? -w_acc_n : w_acc_n;
    assign w_quo   = r_bz ? '1 : (r_neg ? -w_acc_n[XLEN-1:0] : w_acc_n[XLEN-1:0]);
    assign w_remv  = r_neg_a ? -w_rem_n : w_rem_n;
    assign w_res   = r_op[2] ? (r_op[1] ? w_remv : w_quo)
                             : ((r_op[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == IDLE) ? (w_accept ? CALC : IDLE)
               : (r_state == CALC) ? (i_kill_e ? IDLE : (&r_cnt ? DONE : CALC))
               : IDLE;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_m      <= '0;
            r_rem    <= '0;
            r_acc    <= '0;
            r_neg    <= 1'b0;
            r_neg_a  <= 1'b0;
            r_bz     <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt    <= '0;
            r_op     <= i_muldiv_op_e;
            r_m      <= i_muldiv_op_e[2] ? w_mag_b : w_mag_a;
            r_rem    <= '0;
            r_acc    <= {{XLEN{1'b0}}, i_muldiv_op_e[2] ? w_mag_a : w_mag_b};
            r_neg    <= w_sa ^ w_sb;
            r_neg_a  <= w_sa;
            r_bz     <= (i_src_b_e == '0);
        end else if (r_state == CALC && !i_kill_e) begin
            r_cnt    <= r_cnt + CNT_W'(1);
            r_acc    <= w_acc_n;
            r_rem    <= w_rem_n;
            if (&r_cnt) r_result <= w_res;
        end
    end
endmodule
